// File: rtl/mips_pkg.sv
// Shared constants for the MIPS integer datapath.
// Holds the datapath width and the ALU operation codes.
package mips_pkg;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

endpackage

// File: rtl/alu_core.sv
// Purely combinational EX-stage ALU: operation decode, result mux and zero flag.
// Shifts use the instruction shamt field only; unknown op codes yield zero.
module alu_core #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  import mips_pkg::*;

  logic slt_signed;
  logic slt_unsigned;

  assign slt_signed   = $signed(a) < $signed(b);
  assign slt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_signed};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, slt_unsigned};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      ALU_LUI:  result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_arith_unit.sv
// Integer arithmetic for the 5-stage pipeline: EX ALU with registered EX/MEM copy,
// plus the combinational IF PC+4 incrementer and ID branch-target adder.
module exec_arith_unit #(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int OPW   = mips_pkg::OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       shamt,
  input  logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] pc_f,
  input  logic [WIDTH-1:0] pc_plus4_d,
  input  logic [WIDTH-1:0] sign_imm_d,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             zero_q,
  output logic [WIDTH-1:0] pc_plus4_f,
  output logic [WIDTH-1:0] branch_tgt_d
);
  import mips_pkg::*;

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu_core (
    .a      (src_a),
    .b      (src_b),
    .shamt  (shamt),
    .op     (alu_op),
    .result (alu_out),
    .zero   (zero)
  );

  assign pc_plus4_f   = pc_f + WIDTH'(4);
  assign branch_tgt_d = pc_plus4_d + {sign_imm_d[WIDTH-3:0], 2'b00};

  // Reset value mirrors an all-zero result, so zero_q comes out of reset set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else if (!stall) begin
      alu_out_q <= alu_out;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_exec_arith_unit.sv
// Self-checking bench for exec_arith_unit: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_exec_arith_unit;

  localparam longint MOD = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic [3:0]  alu_op;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_d;
  logic [31:0] sign_imm_d;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] alu_out_q;
  logic        zero_q;
  logic [31:0] pc_plus4_f;
  logic [31:0] branch_tgt_d;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q;
  logic        exp_zq;

  always #5 clk = ~clk;

  exec_arith_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .src_a        (src_a),
    .src_b        (src_b),
    .shamt        (shamt),
    .alu_op       (alu_op),
    .pc_f         (pc_f),
    .pc_plus4_d   (pc_plus4_d),
    .sign_imm_d   (sign_imm_d),
    .alu_out      (alu_out),
    .zero         (zero),
    .alu_out_q    (alu_out_q),
    .zero_q       (zero_q),
    .pc_plus4_f   (pc_plus4_f),
    .branch_tgt_d (branch_tgt_d)
  );

  // Reference ALU written as plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint p2 = longint'(1) << sh;
    longint sb = longint'($signed(b));
    longint r;
    case (op)
      4'd0:  r = longint'(a & b);
      4'd1:  r = longint'(a | b);
      4'd2:  r = (ua + ub) % MOD;
      4'd3:  r = longint'(a ^ b);
      4'd4:  r = longint'(~(a | b));
      4'd6:  r = (ua - ub + MOD) % MOD;
      4'd7:  r = (longint'($signed(a)) < sb) ? 1 : 0;
      4'd8:  r = (ua < ub) ? 1 : 0;
      4'd9:  r = (ub * p2) % MOD;
      4'd10: r = ub / p2;
      4'd11: r = ((sb < 0) ? (sb - (p2 - 1)) / p2 : sb / p2) + MOD;
      4'd12: r = (ub % 65536) * 65536;
      default: r = 0;
    endcase
    return 32'(r % MOD);
  endfunction

  function automatic logic [31:0] model_pc4(input logic [31:0] pc);
    return 32'((longint'(pc) + 4) % MOD);
  endfunction

  function automatic logic [31:0] model_btgt(input logic [31:0] pc4, input logic [31:0] imm);
    return 32'((longint'(pc4) + (longint'(imm) * 4) % MOD) % MOD);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Drives ALU inputs just after a falling edge and checks the combinational result.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh, input string tag);
    logic [31:0] e;
    @(negedge clk);
    alu_op = op; src_a = a; src_b = b; shamt = sh;
    #1;
    e = model_alu(op, a, b, sh);
    checkOutput({tag, ".alu_out"}, alu_out, e);
    checkOutput({tag, ".zero"}, 32'(zero), 32'(e == 32'h0));
    if (!stall) begin
      exp_q = e;
      exp_zq = (e == 32'h0);
    end
  endtask

  task automatic tickCheck(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, ".alu_out_q"}, alu_out_q, exp_q);
    checkOutput({tag, ".zero_q"}, 32'(zero_q), 32'(exp_zq));
  endtask

  task automatic pcCheck(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [31:0] e_pc4, input logic [31:0] e_bt, input string tag);
    pc_f = pc; pc_plus4_d = pc4; sign_imm_d = imm;
    #1;
    checkOutput({tag, ".pc_plus4_f"}, pc_plus4_f, e_pc4);
    checkOutput({tag, ".branch_tgt_d"}, branch_tgt_d, e_bt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    src_a = 32'h0; src_b = 32'h0; shamt = 5'd0; alu_op = 4'd2;
    pc_f = 32'h0; pc_plus4_d = 32'h0; sign_imm_d = 32'h0;
    exp_q = 32'h0; exp_zq = 1'b1;
    #2;
    checkOutput("reset.alu_out_q", alu_out_q, 32'h0);
    checkOutput("reset.zero_q", 32'(zero_q), 32'h1);
    @(negedge clk);
    src_a = 32'd7; src_b = 32'd5;
    @(posedge clk); #1;
    checkOutput("reset_held.alu_out_q", alu_out_q, 32'h0);
    checkOutput("reset_held.zero_q", 32'(zero_q), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Directed corner cases with hand-derived expectations.
    applyStimulus(4'b0010, 32'd7, 32'd5, 5'd0, "add");
    checkOutput("add.const", alu_out, 32'd12);
    tickCheck("add");
    checkOutput("add.q_const", alu_out_q, 32'd12);
    applyStimulus(4'b0110, 32'd5, 32'd5, 5'd0, "sub_zero");
    checkOutput("sub_zero.flag", 32'(zero), 32'h1);
    tickCheck("sub_zero");
    applyStimulus(4'b0111, 32'h80000000, 32'd1, 5'd0, "slt");
    checkOutput("slt.const", alu_out, 32'd1);
    applyStimulus(4'b1000, 32'h80000000, 32'd1, 5'd0, "sltu");
    checkOutput("sltu.const", alu_out, 32'd0);
    applyStimulus(4'b1011, 32'h0, 32'h80000000, 5'd4, "sra");
    checkOutput("sra.const", alu_out, 32'hF8000000);
    applyStimulus(4'b1010, 32'h0, 32'h80000000, 5'd4, "srl");
    applyStimulus(4'b1001, 32'h0, 32'h12345678, 5'd0, "sll0");
    checkOutput("sll0.const", alu_out, 32'h12345678);
    applyStimulus(4'b1100, 32'h0, 32'hABCD1234, 5'd0, "lui");
    checkOutput("lui.const", alu_out, 32'h12340000);
    applyStimulus(4'b1111, 32'hFFFF, 32'h1234, 5'd3, "undef");
    checkOutput("undef.const", alu_out, 32'h0);
    applyStimulus(4'b0100, 32'h0, 32'h0, 5'd0, "nor");
    checkOutput("nor.const", alu_out, 32'hFFFFFFFF);
    applyStimulus(4'b0010, 32'hFFFFFFFF, 32'd1, 5'd0, "add_wrap");
    checkOutput("add_wrap.const", alu_out, 32'h0);
    applyStimulus(4'b0110, 32'd0, 32'd1, 5'd0, "sub_wrap");
    checkOutput("sub_wrap.const", alu_out, 32'hFFFFFFFF);
    tickCheck("sub_wrap");

    pcCheck(32'h00400000, 32'h00400010, 32'hFFFFFFFE, 32'h00400004, 32'h00400008, "pc_a");
    pcCheck(32'hFFFFFFFC, 32'h00400010, 32'hFFFFFFFF, 32'h00000000, 32'h0040000C, "pc_b");
    pcCheck(32'h00001000, 32'h00001004, 32'h40000001, 32'h00001004, 32'h00001008, "pc_c");

    // Stall holds the registered copy while the combinational result moves on.
    applyStimulus(4'b0010, 32'd1, 32'd2, 5'd0, "stall_pre");
    tickCheck("stall_pre");
    stall = 1'b1;
    applyStimulus(4'b0010, 32'd4, 32'd5, 5'd0, "stall_hold");
    tickCheck("stall_hold1");
    tickCheck("stall_hold2");
    checkOutput("stall_hold.const", alu_out_q, 32'd3);
    @(negedge clk);
    stall = 1'b0;
    exp_q = 32'd9; exp_zq = 1'b0;
    tickCheck("stall_release");

    // Asynchronous reset asserted between edges during a stall.
    stall = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async_rst.alu_out_q", alu_out_q, 32'h0);
    checkOutput("async_rst.zero_q", 32'(zero_q), 32'h1);
    stall = 1'b0;
    exp_q = 32'h0; exp_zq = 1'b1;
    tickCheck("async_rst_held");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_release.alu_out_q", alu_out_q, 32'h0);
    exp_q = 32'd9; exp_zq = 1'b0;
    tickCheck("rst_first_update");

    // Randomized operations, operands, shifts and stalls.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rp;
      logic [31:0] rq;
      logic [31:0] ri;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: rb = ra;
        2: rb = 32'h80000000;
        3: ra = 32'hFFFFFFFF;
        default: ;
      endcase
      stall = ($urandom_range(0, 3) == 0);
      applyStimulus(4'($urandom_range(0, 15)), ra, rb, 5'($urandom), "rand");
      tickCheck("rand");
      rp = $urandom; rq = $urandom; ri = {{16{rq[15]}}, rq[15:0]};
      if (i % 10 == 0) rp = 32'hFFFFFFFC;
      pcCheck(rp, ra, ri, model_pc4(rp), model_btgt(ra, ri), "rand_pc");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
